// File: rtl/q_maze_pkg.sv
// Shared types and constants for the 6x6 maze Q-learner.
// States are numbered 1..36; 0 is the reset/unused encoding.
package q_maze_pkg;

  localparam int unsigned N_STATES  = 36;
  localparam int unsigned N_ACTIONS = 4;
  localparam int unsigned GRID_W    = 6;

  typedef logic [$clog2(N_STATES + 1)-1:0] state_t;
  typedef logic [1:0]                      action_t;
  typedef logic signed [31:0]              q_t;
  typedef q_t                              q_row_t [N_ACTIONS];

  typedef enum logic [2:0] {
    CtrlIdle   = 3'd0,
    CtrlRead   = 3'd1,
    CtrlSelect = 3'd2,
    CtrlStep   = 3'd3,
    CtrlWait   = 3'd4,
    CtrlUpd    = 3'd5,
    CtrlCheck  = 3'd6,
    CtrlDone   = 3'd7
  } ctrl_state_e;

endpackage

// File: rtl/q_action_select.sv
// Combinational epsilon-greedy action choice over one Q row.
// Greedy pick is a signed argmax with ties resolved to the lowest index.
module q_action_select
  import q_maze_pkg::*;
(
  input  q_row_t       row,
  input  logic [9:0]   rnd,
  input  logic [7:0]   epsilon,
  output action_t      action
);

  action_t best_idx;
  q_t      best_val;

  always_comb begin
    best_idx = '0;
    best_val = row[0];
    // Strict '>' keeps the earlier index on ties.
    for (int unsigned i = 1; i < N_ACTIONS; i++) begin
      if (row[i] > best_val) begin
        best_val = row[i];
        best_idx = action_t'(i);
      end
    end
  end

  assign action = (rnd[7:0] < epsilon) ? rnd[9:8] : best_idx;

endmodule

// File: rtl/q_episode_ctrl.sv
// Episode sequencer: reads a Q row, picks an action, steps the environment,
// scores the move and hands the transition to the Q-update unit.
module q_episode_ctrl
  import q_maze_pkg::*;
#(
  parameter int unsigned NUM_EPISODES = 200,
  parameter int unsigned MAX_STEPS    = 100,
  parameter logic [7:0]  EPSILON      = 8'd26,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1,
  parameter q_t          REWARD_GOAL  = 32'sd100,
  parameter q_t          REWARD_WALL  = -32'sd10,
  parameter q_t          REWARD_STEP  = -32'sd1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  state_t       start_state,
  input  state_t       target_state,
  output logic         q_rd_req,
  output state_t       q_rd_state,
  input  logic         q_rd_ack,
  input  q_row_t       q_rd_row,
  output logic         env_done,
  output state_t       env_state,
  output logic [3:0]   env_action,
  input  logic         env_valid,
  input  state_t       env_next_state,
  output logic         upd_req,
  input  logic         upd_ack,
  output state_t       upd_state,
  output action_t      upd_action,
  output state_t       upd_next,
  output q_t           upd_reward,
  output logic         upd_terminal,
  output logic [15:0]  episode_count,
  output logic [7:0]   step_count,
  output logic         busy,
  output logic         training_done
);

  ctrl_state_e state_q, state_d;
  logic [15:0] lfsr_q, lfsr_d;
  state_t      cur_q, cur_d;
  state_t      nxt_q, nxt_d;
  q_row_t      row_q, row_d;
  action_t     action_q, action_d;
  q_t          reward_q, reward_d;
  logic        terminal_q, terminal_d;
  logic [15:0] ep_q, ep_d;
  logic [7:0]  step_q, step_d;
  action_t     sel_action;

  q_action_select u_select (
    .row     (row_q),
    .rnd     (lfsr_q[9:0]),
    .epsilon (EPSILON),
    .action  (sel_action)
  );

  // Galois form of x^16+x^14+x^13+x^11+1, shifting right.
  assign lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);

  always_comb begin
    state_d    = state_q;
    cur_d      = cur_q;
    nxt_d      = nxt_q;
    row_d      = row_q;
    action_d   = action_q;
    reward_d   = reward_q;
    terminal_d = terminal_q;
    ep_d       = ep_q;
    step_d     = step_q;
    case (state_q)
      CtrlIdle, CtrlDone: begin
        if (start) begin
          cur_d   = start_state;
          ep_d    = '0;
          step_d  = '0;
          state_d = CtrlRead;
        end
      end
      CtrlRead: begin
        if (q_rd_ack) begin
          row_d   = q_rd_row;
          state_d = CtrlSelect;
        end
      end
      CtrlSelect: begin
        action_d = sel_action;
        state_d  = CtrlStep;
      end
      CtrlStep: state_d = CtrlWait;
      CtrlWait: begin
        if (env_valid) begin
          nxt_d      = env_next_state;
          terminal_d = (env_next_state == target_state);
          // Goal outranks wall when the target is also the current cell.
          if (env_next_state == target_state) begin
            reward_d = REWARD_GOAL;
          end else if (env_next_state == cur_q) begin
            reward_d = REWARD_WALL;
          end else begin
            reward_d = REWARD_STEP;
          end
          state_d = CtrlUpd;
        end
      end
      CtrlUpd: begin
        if (upd_ack) begin
          step_d  = (step_q == 8'hFF) ? step_q : step_q + 8'd1;
          state_d = CtrlCheck;
        end
      end
      CtrlCheck: begin
        if (terminal_q || ({24'd0, step_q} == MAX_STEPS)) begin
          ep_d   = ep_q + 16'd1;
          step_d = '0;
          cur_d  = start_state;
        end else begin
          cur_d = nxt_q;
        end
        state_d = ({16'd0, ep_d} == NUM_EPISODES) ? CtrlDone : CtrlRead;
      end
      default: state_d = CtrlIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= CtrlIdle;
      lfsr_q     <= LFSR_SEED;
      cur_q      <= '0;
      nxt_q      <= '0;
      row_q      <= '{default: '0};
      action_q   <= '0;
      reward_q   <= '0;
      terminal_q <= 1'b0;
      ep_q       <= '0;
      step_q     <= '0;
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      cur_q      <= cur_d;
      nxt_q      <= nxt_d;
      row_q      <= row_d;
      action_q   <= action_d;
      reward_q   <= reward_d;
      terminal_q <= terminal_d;
      ep_q       <= ep_d;
      step_q     <= step_d;
    end
  end

  // Interface fields are zeroed outside their own phase so idle buses stay quiet.
  assign q_rd_req      = (state_q == CtrlRead);
  assign q_rd_state    = q_rd_req ? cur_q : '0;
  assign env_done      = (state_q == CtrlStep);
  assign env_state     = env_done ? cur_q : '0;
  assign env_action    = env_done ? {2'b00, action_q} : 4'd0;
  assign upd_req       = (state_q == CtrlUpd);
  assign upd_state     = upd_req ? cur_q : '0;
  assign upd_action    = upd_req ? action_q : '0;
  assign upd_next      = upd_req ? nxt_q : '0;
  assign upd_reward    = upd_req ? reward_q : '0;
  assign upd_terminal  = upd_req & terminal_q;
  assign episode_count = ep_q;
  assign step_count    = step_q;
  assign busy          = (state_q != CtrlIdle) && (state_q != CtrlDone);
  assign training_done = (state_q == CtrlDone);

endmodule

// File: tb/tb_q_episode_ctrl.sv
// Bench for q_episode_ctrl: a greedy (EPSILON=0) and an exploring (EPSILON=128)
// instance share all stimulus; a reference model predicts every output.
module tb_q_episode_ctrl;
  import q_maze_pkg::*;

  localparam int unsigned NumEp    = 2;
  localparam int unsigned MaxSteps = 3;
  localparam logic [15:0] Seed     = 16'hACE1;

  logic   clk = 1'b0;
  logic   rst = 1'b0;
  logic   start = 1'b0;
  state_t start_state = '0;
  state_t target_state = '0;
  logic   q_rd_ack = 1'b0;
  q_row_t q_rd_row = '{default: '0};
  logic   env_valid = 1'b0;
  state_t env_next_state = '0;
  logic   upd_ack = 1'b0;

  logic        q_rd_req [2];
  state_t      q_rd_state [2];
  logic        env_done [2];
  state_t      env_state [2];
  logic [3:0]  env_action [2];
  logic        upd_req [2];
  state_t      upd_state [2];
  action_t     upd_action [2];
  state_t      upd_next [2];
  q_t          upd_reward [2];
  logic        upd_terminal [2];
  logic [15:0] episode_count [2];
  logic [7:0]  step_count [2];
  logic        busy [2];
  logic        training_done [2];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    q_episode_ctrl #(
      .NUM_EPISODES (NumEp),
      .MAX_STEPS    (MaxSteps),
      .EPSILON      ((g == 0) ? 8'd0 : 8'd128),
      .LFSR_SEED    (Seed)
    ) u_dut (
      .clk            (clk),
      .rst            (rst),
      .start          (start),
      .start_state    (start_state),
      .target_state   (target_state),
      .q_rd_req       (q_rd_req[g]),
      .q_rd_state     (q_rd_state[g]),
      .q_rd_ack       (q_rd_ack),
      .q_rd_row       (q_rd_row),
      .env_done       (env_done[g]),
      .env_state      (env_state[g]),
      .env_action     (env_action[g]),
      .env_valid      (env_valid),
      .env_next_state (env_next_state),
      .upd_req        (upd_req[g]),
      .upd_ack        (upd_ack),
      .upd_state      (upd_state[g]),
      .upd_action     (upd_action[g]),
      .upd_next       (upd_next[g]),
      .upd_reward     (upd_reward[g]),
      .upd_terminal   (upd_terminal[g]),
      .episode_count  (episode_count[g]),
      .step_count     (step_count[g]),
      .busy           (busy[g]),
      .training_done  (training_done[g])
    );
  end

  // Reference random source: free-running 16-bit Galois LFSR, mask 0xB400.
  logic [15:0] m_lfsr;
  always @(posedge clk or negedge rst) begin
    if (!rst) m_lfsr <= Seed;
    else      m_lfsr <= {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
  end

  int     total = 0;
  int     bad = 0;
  state_t m_cur, m_start, m_target;
  int     m_ep, m_steps;
  bit     m_done;

  typedef struct {
    q_row_t row;
    state_t nxt;
    int     rd_wait;
    int     env_wait;
    int     upd_wait;
  } vec_t;

  vec_t tbl [11];

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  function automatic logic [95:0] outs(input int g);
    return {4'd0, q_rd_req[g], q_rd_state[g], env_done[g], env_state[g], env_action[g],
            upd_req[g], upd_state[g], upd_action[g], upd_next[g], upd_reward[g],
            upd_terminal[g], episode_count[g], step_count[g], busy[g], training_done[g]};
  endfunction

  function automatic vec_t mk(input q_t a, input q_t b, input q_t c, input q_t d,
                              input state_t nxt, input int rw, input int ew, input int uw);
    vec_t v;
    v.row      = '{a, b, c, d};
    v.nxt      = nxt;
    v.rd_wait  = rw;
    v.env_wait = ew;
    v.upd_wait = uw;
    return v;
  endfunction

  function automatic action_t exp_action(input int g, input q_row_t row, input logic [15:0] rnd);
    logic [7:0] eps;
    int best;
    eps  = (g == 0) ? 8'd0 : 8'd128;
    best = 0;
    if (rnd[7:0] < eps) return rnd[9:8];
    for (int i = 1; i < 4; i++) if (row[i] > row[best]) best = i;
    return action_t'(best);
  endfunction

  function automatic q_t exp_reward(input state_t nxt, input state_t cur, input state_t tgt);
    if (nxt == tgt) return 32'sd100;
    if (nxt == cur) return -32'sd10;
    return -32'sd1;
  endfunction

  task automatic chk_upd(input action_t a0, input action_t a1, input state_t nx, input q_t rw,
                         input logic tm);
    for (int g = 0; g < 2; g++) begin
      chk("upd_req", upd_req[g], 1);
      chk("upd_state", upd_state[g], m_cur);
      chk("upd_action", upd_action[g], (g == 0) ? a0 : a1);
      chk("upd_next", upd_next[g], nx);
      chk("upd_reward", upd_reward[g], rw);
      chk("upd_terminal", upd_terminal[g], tm);
      chk("env_done_quiet", env_done[g], 0);
    end
  endtask

  task automatic start_run(input state_t s, input state_t t);
    start_state  = s;
    target_state = t;
    start = 1'b1;
    cyc();
    start = 1'b0;
    m_start = s; m_target = t; m_cur = s;
    m_ep = 0; m_steps = 0; m_done = 1'b0;
    for (int g = 0; g < 2; g++) begin
      chk("start_busy", busy[g], 1);
      chk("start_ep", episode_count[g], 0);
      chk("start_steps", step_count[g], 0);
    end
  endtask

  task automatic run_step(input vec_t v);
    int n;
    logic [15:0] rnd;
    action_t act [2];
    q_t rew;
    logic term;
    n = 0;
    while (q_rd_req[0] !== 1'b1 && n < 8) begin cyc(); n++; end
    for (int g = 0; g < 2; g++) begin
      chk("rd_req", q_rd_req[g], 1);
      chk("rd_state", q_rd_state[g], m_cur);
    end
    repeat (v.rd_wait) cyc();
    q_rd_ack = 1'b1;
    q_rd_row = v.row;
    cyc();
    q_rd_ack = 1'b0;
    rnd = m_lfsr;
    for (int g = 0; g < 2; g++) begin
      chk("select_quiet", {q_rd_req[g], env_done[g]}, 0);
      act[g] = exp_action(g, v.row, rnd);
    end
    cyc();
    for (int g = 0; g < 2; g++) begin
      chk("env_done", env_done[g], 1);
      chk("env_state", env_state[g], m_cur);
      chk("env_action", env_action[g], {2'b00, act[g]});
    end
    cyc();
    for (int g = 0; g < 2; g++) chk("env_done_once", env_done[g], 0);
    // Stray acks while waiting on the environment must be ignored.
    repeat (v.env_wait) begin q_rd_ack = 1'b1; upd_ack = 1'b1; cyc(); end
    q_rd_ack = 1'b0;
    upd_ack = 1'b0;
    env_valid = 1'b1;
    env_next_state = v.nxt;
    cyc();
    env_valid = 1'b0;
    rew  = exp_reward(v.nxt, m_cur, m_target);
    term = (v.nxt == m_target);
    chk_upd(act[0], act[1], v.nxt, rew, term);
    for (int i = 0; i < v.upd_wait; i++) begin
      env_valid = ~env_valid;
      env_next_state = ~v.nxt;
      start = i[0];
      cyc();
      chk_upd(act[0], act[1], v.nxt, rew, term);
      for (int g = 0; g < 2; g++) chk("stall_steps", step_count[g], m_steps);
    end
    env_valid = 1'b0;
    start = 1'b0;
    upd_ack = 1'b1;
    cyc();
    upd_ack = 1'b0;
    m_steps = (m_steps == 255) ? 255 : m_steps + 1;
    for (int g = 0; g < 2; g++) begin
      chk("ack_steps", step_count[g], m_steps);
      chk("upd_req_drop", upd_req[g], 0);
    end
    if (term || m_steps == MaxSteps) begin
      m_ep++;
      m_steps = 0;
      m_cur = m_start;
    end else begin
      m_cur = v.nxt;
    end
    m_done = (m_ep == NumEp);
    cyc();
    for (int g = 0; g < 2; g++) begin
      chk("ep_count", episode_count[g], m_ep);
      chk("step_count", step_count[g], m_steps);
      chk("training_done", training_done[g], m_done);
      chk("busy", busy[g], !m_done);
      chk("next_rd_req", q_rd_req[g], !m_done);
      if (!m_done) chk("next_rd_state", q_rd_state[g], m_cur);
    end
  endtask

  initial begin
    tbl[0]  = mk(5, -3, 9, 9, 6'd2, 0, 0, 0);
    tbl[1]  = mk(0, 0, 0, 0, 6'd36, 2, 1, 0);
    tbl[2]  = mk(-1, -2, -3, -4, 6'd8, 0, 0, 0);
    tbl[3]  = mk(1, 2, 3, 4, 6'd8, 1, 2, 10);
    tbl[4]  = mk(-5, 7, 7, -9, 6'd9, 0, 0, 1);
    tbl[5]  = mk(-100, -100, -7, -100, 6'd4, 0, 0, 0);
    tbl[6]  = mk(3, 3, 3, 3, 6'd4, 0, 0, 0);
    tbl[7]  = mk(0, 1, 0, 2, 6'd10, 3, 0, 2);
    tbl[8]  = mk(9, 0, 0, 0, 6'd3, 0, 0, 0);
    tbl[9]  = mk(-2, 5, 1, 5, 6'd11, 0, 1, 0);
    tbl[10] = mk(32'sh7FFFFFFF, 32'sh80000000, 0, 1, 6'd12, 0, 0, 0);

    repeat (3) cyc();
    for (int g = 0; g < 2; g++) chk("reset_outs", outs(g), '0);
    #2 rst = 1'b1;
    cyc();
    for (int g = 0; g < 2; g++) chk("idle_outs", outs(g), '0);

    // Goal, wall and truncation: 5 steps, 2 episodes.
    start_run(6'd1, 6'd36);
    for (int i = 0; i < 5; i++) run_step(tbl[i]);
    // Two truncated episodes from DONE: done after the 6th update.
    start_run(6'd3, 6'd36);
    for (int i = 5; i < 11; i++) run_step(tbl[i]);

    // Reset while waiting on the environment.
    start_run(6'd5, 6'd30);
    q_rd_ack = 1'b1;
    q_rd_row = '{1, 2, 3, 4};
    cyc();
    q_rd_ack = 1'b0;
    cyc();
    cyc();
    for (int g = 0; g < 2; g++) chk("wait_busy", busy[g], 1);
    #2 rst = 1'b0;
    #1;
    for (int g = 0; g < 2; g++) chk("async_reset_outs", outs(g), '0);
    @(negedge clk);
    #2 rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      env_valid = 1'b1;
      upd_ack = 1'b1;
      q_rd_ack = 1'b1;
      cyc();
      for (int g = 0; g < 2; g++) chk("post_reset_quiet", {upd_req[g], busy[g]}, 0);
    end
    env_valid = 1'b0;
    upd_ack = 1'b0;
    q_rd_ack = 1'b0;

    // Randomised runs; the first has target == start.
    for (int r = 0; r < 10; r++) begin
      state_t s, t;
      int guard;
      s = state_t'($urandom_range(1, 36));
      t = (r == 0) ? s : state_t'($urandom_range(1, 36));
      start_run(s, t);
      guard = 0;
      while (!m_done && guard < 8) begin
        vec_t v;
        int p;
        q_t e [4];
        state_t nx;
        for (int k = 0; k < 4; k++)
          e[k] = ($urandom_range(0, 3) == 0) ? $signed($urandom)
                                             : q_t'($urandom_range(0, 8)) - 32'sd4;
        p = $urandom_range(0, 9);
        if (p < 3)       nx = m_target;
        else if (p < 5)  nx = m_cur;
        else if (p == 5) nx = $urandom_range(0, 1) ? 6'd0 : 6'd63;
        else             nx = state_t'($urandom_range(1, 36));
        v = mk(e[0], e[1], e[2], e[3], nx, $urandom_range(0, 3), $urandom_range(0, 2),
               $urandom_range(0, 3));
        run_step(v);
        guard++;
      end
      chk("random_run_done", m_done, 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
